// File: rtl/multicycle_seq_ctrl.sv
// Control sequencer for a multicycle datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the datapath
// register enables, mux selects and memory handshake. It also counts retired
// instructions and traps to ERR when a memory request waits too long.
module multicycle_seq_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int RET_W       = 32
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             run,
   input  logic [2:0]       cls,
   input  logic             br_taken,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             mem_addr_sel,
   output logic             pc_en,
   output logic             ir_en,
   output logic             a_en,
   output logic             b_en,
   output logic             alu_en,
   output logic             mdr_en,
   output logic [1:0]       pc_src,
   output logic             rf_we,
   output logic             wb_sel,
   output logic [2:0]       state,
   output logic             halted,
   output logic             err,
   output logic [RET_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6,
      S_ERR    = 3'd7
   } state_t;

   localparam logic [2:0] CLS_ALU    = 3'd0;
   localparam logic [2:0] CLS_LOAD   = 3'd1;
   localparam logic [2:0] CLS_STORE  = 3'd2;
   localparam logic [2:0] CLS_BRANCH = 3'd3;
   localparam logic [2:0] CLS_JUMP   = 3'd4;
   localparam logic [2:0] CLS_HALT   = 3'd5;

   // The counter never needs to exceed MEM_TIMEOUT-1: at that value the next miss traps.
   localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_LAST =
      (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;
   localparam bit TIMEOUT_ON = (MEM_TIMEOUT > 0);

   state_t            r_state;
   state_t            w_state_next;
   logic [2:0]        r_cls;
   logic [WAIT_W-1:0] r_wait;
   logic [RET_W-1:0]  r_retired;
   logic              w_instr_end;
   logic              w_timeout;
   logic              w_mem_phase;

   assign state   = r_state;
   assign retired = r_retired;

   // Memory-facing states are the only ones whose wait cycles are counted.
   assign w_mem_phase = (r_state == S_FETCH) || (r_state == S_MEM);

   // A miss on the last allowed wait cycle traps; a ready in that cycle still wins.
   assign w_timeout = TIMEOUT_ON && w_mem_phase && (r_wait == WAIT_LAST) && !mem_ready;

   // State register plus the class latched in DECODE for use in later phases.
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         r_state <= S_IDLE;
         r_cls   <= 3'd0;
      end else begin
         r_state <= w_state_next;
         if (r_state == S_DECODE) begin
            r_cls <= cls;
         end
      end
   end

   // Wait counter: counts unanswered memory cycles, cleared on ready or any state change.
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         r_wait <= '0;
      end else if (mem_ready || !w_mem_phase || (w_state_next != r_state)) begin
         r_wait <= '0;
      end else begin
         r_wait <= r_wait + 1'b1;
      end
   end

   // Retired-instruction counter, wraps naturally at 2^RET_W.
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         r_retired <= '0;
      end else if (w_instr_end) begin
         r_retired <= r_retired + RET_W'(1);
      end
   end

   // Next-state and per-state datapath controls.
   always_comb begin
      w_state_next = r_state;
      w_instr_end  = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      pc_en        = 1'b0;
      ir_en        = 1'b0;
      a_en         = 1'b0;
      b_en         = 1'b0;
      alu_en       = 1'b0;
      mdr_en       = 1'b0;
      pc_src       = 2'd0;
      rf_we        = 1'b0;
      wb_sel       = 1'b0;
      halted       = 1'b0;
      err          = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (run) begin
               w_state_next = S_FETCH;
            end
         end
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_en        = 1'b1;
               pc_en        = 1'b1;
               w_state_next = S_DECODE;
            end else if (w_timeout) begin
               w_state_next = S_ERR;
            end
         end
         S_DECODE: begin
            a_en = 1'b1;
            b_en = 1'b1;
            if (cls == CLS_HALT) begin
               w_state_next = S_HALT;
            end else if (cls > CLS_HALT) begin
               w_state_next = S_ERR;
            end else begin
               w_state_next = S_EXEC;
            end
         end
         S_EXEC: begin
            alu_en = 1'b1;
            case (r_cls)
               CLS_ALU: w_state_next = S_WB;
               CLS_LOAD, CLS_STORE: w_state_next = S_MEM;
               CLS_BRANCH: begin
                  if (br_taken) begin
                     pc_en  = 1'b1;
                     pc_src = 2'd1;
                  end
                  w_instr_end = 1'b1;
               end
               CLS_JUMP: begin
                  pc_en       = 1'b1;
                  pc_src      = 2'd2;
                  w_instr_end = 1'b1;
               end
               // Only classes 0-4 can reach EXEC; anything else is treated as corrupt.
               default: w_state_next = S_ERR;
            endcase
         end
         S_MEM: begin
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
            mem_we       = (r_cls == CLS_STORE);
            if (mem_ready) begin
               if (r_cls == CLS_LOAD) begin
                  mdr_en       = 1'b1;
                  w_state_next = S_WB;
               end else begin
                  w_instr_end = 1'b1;
               end
            end else if (w_timeout) begin
               w_state_next = S_ERR;
            end
         end
         S_WB: begin
            rf_we       = 1'b1;
            wb_sel      = (r_cls == CLS_LOAD);
            w_instr_end = 1'b1;
         end
         S_HALT: halted = 1'b1;
         S_ERR:  err    = 1'b1;
      endcase

      // A finishing instruction always completes; run only picks what follows it.
      if (w_instr_end) begin
         w_state_next = run ? S_FETCH : S_IDLE;
      end
   end

endmodule
